apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- Synthesizable, parametrised APB master.
- Converts a simple valid/ready command stream from an internal requester into APB setup/access transfers.
- Returns read data and error status on a valid/ready response channel.
- Sits between the CPU-side logic and the APB decoder/slaves. It is the RTL successor of the task-based CPU bus model.

Parameters:
- ADDR_WIDTH, 8, width of cmd_addr and paddr.
- DATA_WIDTH, 8, width of cmd_wdata, pwdata, prdata and rsp_rdata.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with pready low before abort. Used only with APB_TIMEOUT_EN. Must be ≥1.

Ports:
- pclk  in  1  APB clock; all state on rising edge.
- presetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  requester has a command.
- cmd_ready  out  1  bridge accepts a command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  requester consumes the response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errors.
- rsp_err  out  1  pslverr was seen, or a timeout occurred.
- rsp_timeout  out  1  transfer was aborted by timeout.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (async, presetn low):
  - State goes to IDLE.
  - psel, penable, pwrite, rsp_valid, rsp_err and rsp_timeout = 0.
  - paddr, pwdata and rsp_rdata = 0.
  - cmd_ready = 1 once out of reset.
  - Reset mid-transfer drops psel/penable immediately and discards any pending response.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered; cmd_ready is decoded from state (IDLE only).
- IDLE: when cmd_valid and cmd_ready are both high at edge N:
  - Latch cmd_write, cmd_addr and cmd_wdata (wdata is latched as 0 for reads).
  - Go to SETUP.
  - In cycle N+1: psel=1, penable=0, and paddr/pwdata/pwrite show the latched values.
- SETUP: go to ACCESS unconditionally. penable=1 from cycle N+2.
- ACCESS:
  - paddr, pwdata, pwrite and psel are held stable.
  - pready low: stay in ACCESS. pslverr and prdata are ignored.
  - pready high at edge M:
    - Capture rsp_rdata = prdata for reads; 0 for writes, or when pslverr=1.
    - Capture rsp_err = pslverr.
    - psel=0, penable=0 and pwrite=0 from cycle M+1.
    - paddr holds its last value; pwdata clears to 0.
    - Go to RESP with rsp_valid=1 in cycle M+1.
- Minimum latency with zero wait states: acceptance edge N → rsp_valid at N+3.
- RESP:
  - rsp_valid and the rsp_* fields are held stable until rsp_valid and rsp_ready are both high.
  - Then go to IDLE: rsp_valid=0 and cmd_ready=1 on the next cycle.
  - No new command is accepted while in RESP. This is a single-outstanding design.
  - rsp_ready asserted before rsp_valid has no effect.
- Changes on cmd_* while cmd_ready=0 are ignored.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro defined:
  - A counter (width $clog2(TIMEOUT_CYCLES+1)) clears on entry to ACCESS and increments on each ACCESS cycle with pready low.
  - When the counter equals TIMEOUT_CYCLES and pready is still low, the transfer aborts: same exit as a normal completion, but rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - If pready goes high on the same edge the count is reached, pready wins and the transfer completes normally.
- Without the macro: ACCESS waits indefinitely, no counter logic exists, and rsp_timeout is tied to 0.

Decomposition:
- Shared package apb_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/RESP);
  - the default widths;
  - the response struct {rdata, err, timeout}.
- One sub-module: apb_timeout_cnt (counter with clear, enable and reached flag), instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Write, zero wait: cmd addr 0x10 data 0xA5 → psel high 1 cycle with penable=0, then penable high 1 cycle, pwrite=1; rsp_valid 3 cycles after accept with rsp_err=0 and rsp_rdata=0.
- Read with 2 wait states: addr 0x20, slave returns prdata 0x3C on third ACCESS cycle → rsp_rdata=0x3C, rsp_valid 5 cycles after accept, paddr stable throughout.
- Slave error: read addr 0xFF, pslverr=1 with pready=1 → rsp_err=1, rsp_rdata=0, psel drops next cycle.
- Response backpressure: rsp_ready held low for 4 cycles, cmd_valid held high → cmd_ready stays 0, rsp fields stable; second command accepted the cycle after rsp handshake.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=4): pready tied low → abort after 4 wait cycles with rsp_err=1 and rsp_timeout=1. Without the macro, the bridge is still in ACCESS after 100 cycles.
- Reset mid-ACCESS: presetn low → psel, penable and rsp_valid are 0 immediately; after release, cmd_ready=1 and the next write completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared declarations for the APB master bridge:
//   - apb_state_e : bridge FSM states (IDLE / SETUP / ACCESS / RESP)
//   - default address/data widths and default timeout depth
//   - apb_rsp_t   : response record {rdata, err, timeout} at the default width
// No ports (package).
// -----------------------------------------------------------------------------
package apb_pkg;

   localparam int APB_ADDR_WIDTH_DEF     = 8;
   localparam int APB_DATA_WIDTH_DEF     = 8;
   localparam int APB_TIMEOUT_CYCLES_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

   // Response record at the default data width. The bridge declares a
   // same-layout record sized by its own DATA_WIDTH parameter.
   typedef struct packed {
      logic [APB_DATA_WIDTH_DEF-1:0] rdata;
      logic                          err;
      logic                          timeout;
   } apb_rsp_t;

endpackage : apb_pkg

// File: rtl/apb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// apb_timeout_cnt
// Wait-state counter used to abort an APB transfer whose slave never asserts
// pready. Counts up while en is high, saturates at MAX_COUNT, and flags when
// that count has been reached.
// Ports:
//   pclk    in  clock, rising edge
//   presetn in  asynchronous active-low reset
//   clr     in  synchronous clear (takes priority over en)
//   en      in  count one wait cycle
//   reached out count equals MAX_COUNT
// -----------------------------------------------------------------------------
module apb_timeout_cnt #(
   parameter int MAX_COUNT = 16
) (
   input  logic pclk,
   input  logic presetn,
   input  logic clr,
   input  logic en,
   output logic reached
);

   localparam int CW = $clog2(MAX_COUNT + 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && !reached) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign reached = (cnt_q == CW'(MAX_COUNT));

endmodule : apb_timeout_cnt

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// Single-outstanding APB master. Accepts one command on the cmd_* channel,
// runs it as an APB SETUP + ACCESS transfer, and returns the result on the
// rsp_* channel before accepting the next command.
//
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES wait cycles (rsp_err=1, rsp_timeout=1, rsp_rdata=0).
// Without it, ACCESS waits indefinitely and rsp_timeout stays 0.
//
// Handshakes: a beat transfers on a rising pclk edge where valid and ready
// are both high; once valid is raised its payload is held stable until that
// edge, and ready may not depend on valid in the same cycle.
//
// Ports:
//   pclk, presetn               clock / async active-low reset
//   cmd_valid, cmd_ready        command handshake (ready only in IDLE)
//   cmd_write, cmd_addr,
//   cmd_wdata                   command payload
//   rsp_valid, rsp_ready        response handshake
//   rsp_rdata, rsp_err,
//   rsp_timeout                 response payload
//   paddr, pwdata, pwrite,
//   psel, penable               APB request (all registered)
//   prdata, pready, pslverr     APB completion from the slave
// -----------------------------------------------------------------------------
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = APB_ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH     = APB_DATA_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES_DEF
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   output logic                  pwrite,
   output logic                  psel,
   output logic                  penable,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
   end

   typedef struct packed {
      logic [DATA_WIDTH-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } rsp_t;

   apb_state_e            state_q, state_d;

   logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
   logic                  pwrite_q,  pwrite_d;
   logic                  psel_q,    psel_d;
   logic                  penable_q, penable_d;
   logic                  rsp_valid_q, rsp_valid_d;
   rsp_t                  rsp_q,     rsp_d;

   logic                  timeout_hit;

   // ---------------------------------------------------------------------------
   // Optional ACCESS-phase timeout. The counter is cleared during SETUP, which
   // always precedes ACCESS, so it starts from zero on every transfer. pready
   // high on the same edge the limit is reached completes normally.
   // ---------------------------------------------------------------------------
`ifdef APB_TIMEOUT_EN
   logic to_reached;

   apb_timeout_cnt #(
      .MAX_COUNT (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .pclk    (pclk),
      .presetn (presetn),
      .clr     (state_q == ST_SETUP),
      .en      ((state_q == ST_ACCESS) && !pready),
      .reached (to_reached)
   );

   assign timeout_hit = (state_q == ST_ACCESS) && !pready && to_reached;
`else
   assign timeout_hit = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (cmd_valid)              state_d = ST_SETUP;
         ST_SETUP:                              state_d = ST_ACCESS;
         ST_ACCESS: if (pready || timeout_hit)  state_d = ST_RESP;
         ST_RESP:   if (rsp_ready)              state_d = ST_IDLE;
         default:                               state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs. Computes the next value of every registered output; the
   // registers below make all bridge outputs glitch-free flops.
   // ---------------------------------------------------------------------------
   always_comb begin
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      rsp_valid_d = rsp_valid_q;
      rsp_d       = rsp_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               psel_d    = 1'b1;
               penable_d = 1'b0;
               paddr_d   = cmd_addr;
               pwrite_d  = cmd_write;
               pwdata_d  = cmd_write ? cmd_wdata : '0;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
         end
         ST_ACCESS: begin
            if (pready || timeout_hit) begin
               // paddr deliberately holds its last value after the transfer.
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               pwrite_d    = 1'b0;
               pwdata_d    = '0;
               rsp_valid_d = 1'b1;
               if (pready) begin
                  rsp_d.rdata   = (pwrite_q || pslverr) ? '0 : prdata;
                  rsp_d.err     = pslverr;
                  rsp_d.timeout = 1'b0;
               end else begin
                  rsp_d.rdata   = '0;
                  rsp_d.err     = 1'b1;
                  rsp_d.timeout = 1'b1;
               end
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
      end else begin
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
      end
   end

   assign cmd_ready   = (state_q == ST_IDLE);
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign pwrite      = pwrite_q;
   assign psel        = psel_q;
   assign penable     = penable_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_q.rdata;
   assign rsp_err     = rsp_q.err;
   assign rsp_timeout = rsp_q.timeout;

endmodule : apb_master_bridge
